wb_stage_commit: RTL and testbench

//  Write-back stage register and commit unit. Consumes the WB control bundle produced upstream
//  (memToReg, regwrite, HI/LO read/write) with its data. Owns the architectural HI/LO registers.

---
 rtl/wb_stage_commit_pkg.sv | 46 ++++
 rtl/wb_stage_commit_if.sv | 32 +++
 rtl/wb_stage_commit_hilo_regs.sv | 48 ++++
 rtl/wb_stage_commit.sv | 105 ++++++++++
 tb/tb_wb_stage_commit.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_stage_commit_pkg.sv
// Shared write-back definitions: memToReg encodings, WB state, payload bundle
// and the regfile write-data selector.
package wb_stage_commit_pkg;

  localparam logic [1:0] MTR_RES  = 2'b00;
  localparam logic [1:0] MTR_HILO = 2'b01;
  localparam logic [1:0] MTR_LINK = 2'b10;
  localparam logic [1:0] MTR_CP0  = 2'b11;

  typedef enum logic {
    WS_EMPTY = 1'b0,
    WS_FULL  = 1'b1
  } ws_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  dest;
    logic [1:0]  mem_to_reg;
    logic        regwrite;
    logic        hi_read;
    logic        lo_read;
    logic        hi_write;
    logic        lo_write;
    logic [31:0] result;
    logic [31:0] link;
    logic [31:0] cp0_rdata;
    logic [31:0] hi_wdata;
    logic [31:0] lo_wdata;
  } ws_payload_t;

  // HI/LO source is the pre-update register value, so a same-bundle write never bypasses.
  function automatic logic [31:0] wb_wdata_sel(input ws_payload_t p,
                                               input logic [31:0] hi,
                                               input logic [31:0] lo);
    logic [31:0] w;
    case (p.mem_to_reg)
      MTR_RES:  w = p.result;
      MTR_HILO: w = p.hi_read ? hi : lo;
      MTR_LINK: w = p.link;
      MTR_CP0:  w = p.cp0_rdata;
      default:  w = 32'h0;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/wb_stage_commit_if.sv
// MEM -> WB pipeline handshake and payload bundle.
interface wb_stage_commit_if;
  logic        ms_to_ws_valid;
  logic        ws_allowin;
  logic [31:0] ms_pc;
  logic [4:0]  ms_dest;
  logic [1:0]  ms_memToReg;
  logic        ms_regwrite;
  logic        ms_hi_read;
  logic        ms_lo_read;
  logic        ms_hi_write;
  logic        ms_lo_write;
  logic [31:0] ms_result;
  logic [31:0] ms_link;
  logic [31:0] ms_cp0_rdata;
  logic [31:0] ms_hi_wdata;
  logic [31:0] ms_lo_wdata;

  modport master (
    output ms_to_ws_valid, ms_pc, ms_dest, ms_memToReg, ms_regwrite,
           ms_hi_read, ms_lo_read, ms_hi_write, ms_lo_write,
           ms_result, ms_link, ms_cp0_rdata, ms_hi_wdata, ms_lo_wdata,
    input  ws_allowin
  );

  modport slave (
    input  ms_to_ws_valid, ms_pc, ms_dest, ms_memToReg, ms_regwrite,
           ms_hi_read, ms_lo_read, ms_hi_write, ms_lo_write,
           ms_result, ms_link, ms_cp0_rdata, ms_hi_wdata, ms_lo_wdata,
    output ws_allowin
  );
endinterface

// File: rtl/wb_stage_commit_hilo_regs.sv
// Architectural HI/LO registers with independent write enables.
module hilo_regs
  import wb_stage_commit_pkg::*;
#(
  parameter logic [31:0] HILO_RST = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic [31:0] hi_d,
  input  logic [31:0] lo_d,
  output logic [31:0] hi_q,
  output logic [31:0] lo_q
);

  logic [31:0] hi_reg_d, hi_reg_q;
  logic [31:0] lo_reg_d, lo_reg_q;

  always_comb begin
    hi_reg_d = hi_reg_q;
    lo_reg_d = lo_reg_q;
    if (hi_we) begin
      hi_reg_d = hi_d;
    end else begin
      hi_reg_d = hi_reg_q;
    end
    if (lo_we) begin
      lo_reg_d = lo_d;
    end else begin
      lo_reg_d = lo_reg_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi_reg_q <= HILO_RST;
      lo_reg_q <= HILO_RST;
    end else begin
      hi_reg_q <= hi_reg_d;
      lo_reg_q <= lo_reg_d;
    end
  end

  assign hi_q = hi_reg_q;
  assign lo_q = lo_reg_q;

endmodule

// File: rtl/wb_stage_commit.sv
// Write-back stage register and commit unit: captures the MEM bundle, drives the
// regfile write port, forwarding info and debug trace, and owns HI/LO.
module wb_stage_commit
  import wb_stage_commit_pkg::*;
#(
  parameter logic [31:0] HILO_RST = 32'h0,
  parameter logic [31:0] PC_RST   = 32'hbfc00000
) (
  input  logic                    clk,
  input  logic                    reset,
  wb_stage_commit_if.slave        ms,
  input  logic                    wb_flush,
  output logic                    rf_we,
  output logic [4:0]              rf_waddr,
  output logic [31:0]             rf_wdata,
  output logic                    ws_fwd_valid,
  output logic [4:0]              ws_fwd_dest,
  output logic [31:0]             hi_q,
  output logic [31:0]             lo_q,
  output logic [31:0]             debug_wb_pc,
  output logic [3:0]              debug_wb_rf_wen,
  output logic [4:0]              debug_wb_rf_wnum,
  output logic [31:0]             debug_wb_rf_wdata
);

  localparam ws_payload_t PAY_RST = '{pc: PC_RST, default: '0};

  ws_state_e   state_d, state_q;
  ws_payload_t pay_d, pay_q;
  ws_payload_t pay_in;
  logic        capture;
  logic        ws_valid;
  logic        hi_we, lo_we;

  assign ms.ws_allowin = 1'b1;

  assign pay_in = '{
    pc:         ms.ms_pc,
    dest:       ms.ms_dest,
    mem_to_reg: ms.ms_memToReg,
    regwrite:   ms.ms_regwrite,
    hi_read:    ms.ms_hi_read,
    lo_read:    ms.ms_lo_read,
    hi_write:   ms.ms_hi_write,
    lo_write:   ms.ms_lo_write,
    result:     ms.ms_result,
    link:       ms.ms_link,
    cp0_rdata:  ms.ms_cp0_rdata,
    hi_wdata:   ms.ms_hi_wdata,
    lo_wdata:   ms.ms_lo_wdata
  };

  // A flush only blocks the incoming entry; the one already held still commits.
  always_comb begin
    state_d = state_q;
    pay_d   = pay_q;
    capture = ms.ms_to_ws_valid & ~wb_flush;
    if (capture) begin
      state_d = WS_FULL;
      pay_d   = pay_in;
    end else begin
      state_d = WS_EMPTY;
      pay_d   = pay_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= WS_EMPTY;
      pay_q   <= PAY_RST;
    end else begin
      state_q <= state_d;
      pay_q   <= pay_d;
    end
  end

  assign ws_valid = (state_q == WS_FULL);
  assign hi_we    = ws_valid & pay_q.hi_write;
  assign lo_we    = ws_valid & pay_q.lo_write;

  hilo_regs #(
    .HILO_RST (HILO_RST)
  ) u_hilo (
    .clk   (clk),
    .reset (reset),
    .hi_we (hi_we),
    .lo_we (lo_we),
    .hi_d  (pay_q.hi_wdata),
    .lo_d  (pay_q.lo_wdata),
    .hi_q  (hi_q),
    .lo_q  (lo_q)
  );

  assign rf_we        = ws_valid & pay_q.regwrite & (pay_q.dest != 5'd0);
  assign rf_waddr     = pay_q.dest;
  assign rf_wdata     = wb_wdata_sel(pay_q, hi_q, lo_q);
  assign ws_fwd_valid = rf_we;
  assign ws_fwd_dest  = rf_we ? pay_q.dest : 5'd0;

  assign debug_wb_pc       = pay_q.pc;
  assign debug_wb_rf_wen   = {4{rf_we}};
  assign debug_wb_rf_wnum  = rf_waddr;
  assign debug_wb_rf_wdata = rf_wdata;

endmodule

// File: tb/tb_wb_stage_commit.sv
// Scoreboard bench for wb_stage_commit: stimulus pushes expected commits tagged
// with the cycle they must appear in; a monitor compares every cycle.
module tb_wb_stage_commit;

  typedef struct {
    logic        valid;
    logic [31:0] pc;
    logic [4:0]  dest;
    logic [1:0]  mtr;
    logic        regwrite, hi_read, lo_read, hi_write, lo_write;
    logic [31:0] result, link, cp0, hiw, low;
  } ins_t;

  typedef struct {
    int unsigned cyc;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata, pc, hi, lo;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic wb_flush = 1'b0;
  logic rf_we, ws_fwd_valid;
  logic [4:0] rf_waddr, ws_fwd_dest, debug_wb_rf_wnum;
  logic [31:0] rf_wdata, hi_q, lo_q, debug_wb_pc, debug_wb_rf_wdata;
  logic [3:0] debug_wb_rf_wen;

  int checks = 0;
  int failures = 0;
  int unsigned cyc = 0;
  bit mon_en = 1'b0;
  exp_t sb[$];
  logic [31:0] m_hi = 32'h0;
  logic [31:0] m_lo = 32'h0;

  wb_stage_commit_if ms_if();

  wb_stage_commit dut (
    .clk               (clk),
    .reset             (reset),
    .ms                (ms_if),
    .wb_flush          (wb_flush),
    .rf_we             (rf_we),
    .rf_waddr          (rf_waddr),
    .rf_wdata          (rf_wdata),
    .ws_fwd_valid      (ws_fwd_valid),
    .ws_fwd_dest       (ws_fwd_dest),
    .hi_q              (hi_q),
    .lo_q              (lo_q),
    .debug_wb_pc       (debug_wb_pc),
    .debug_wb_rf_wen   (debug_wb_rf_wen),
    .debug_wb_rf_wnum  (debug_wb_rf_wnum),
    .debug_wb_rf_wdata (debug_wb_rf_wdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic ins_t blank();
    ins_t i;
    i = '{valid: 1'b1, pc: 32'h0, dest: 5'd0, mtr: 2'b00, regwrite: 1'b0,
          hi_read: 1'b0, lo_read: 1'b0, hi_write: 1'b0, lo_write: 1'b0,
          result: 32'h0, link: 32'h0, cp0: 32'h0, hiw: 32'h0, low: 32'h0};
    return i;
  endfunction

  // Reference model: commits happen in issue order, one cycle after capture.
  task automatic drive_now(input ins_t i, input logic flush, input bit push);
    exp_t e;
    ms_if.ms_to_ws_valid = i.valid;
    ms_if.ms_pc = i.pc;           ms_if.ms_dest = i.dest;
    ms_if.ms_memToReg = i.mtr;    ms_if.ms_regwrite = i.regwrite;
    ms_if.ms_hi_read = i.hi_read; ms_if.ms_lo_read = i.lo_read;
    ms_if.ms_hi_write = i.hi_write; ms_if.ms_lo_write = i.lo_write;
    ms_if.ms_result = i.result;   ms_if.ms_link = i.link;
    ms_if.ms_cp0_rdata = i.cp0;   ms_if.ms_hi_wdata = i.hiw;
    ms_if.ms_lo_wdata = i.low;
    wb_flush = flush;
    if (push && i.valid && !flush) begin
      e.cyc = cyc + 1;
      e.we = i.regwrite && (i.dest != 5'd0);
      e.waddr = i.dest;
      e.pc = i.pc;
      e.hi = m_hi;
      e.lo = m_lo;
      if (i.mtr == 2'b00) e.wdata = i.result;
      else if (i.mtr == 2'b01) e.wdata = i.hi_read ? m_hi : m_lo;
      else if (i.mtr == 2'b10) e.wdata = i.link;
      else e.wdata = i.cp0;
      sb.push_back(e);
      if (i.hi_write) m_hi = i.hiw;
      if (i.lo_write) m_lo = i.low;
    end
  endtask

  task automatic issue(input ins_t i, input logic flush);
    @(posedge clk);
    #1;
    drive_now(i, flush, 1'b1);
  endtask

  task automatic idle();
    ins_t i;
    i = blank();
    i.valid = 1'b0;
    issue(i, 1'b0);
  endtask

  // Monitor: compare a due commit, otherwise expect no regfile write.
  always @(negedge clk) begin
    if (mon_en) begin
      if (sb.size() > 0 && sb[0].cyc == cyc) begin
        exp_t e;
        e = sb.pop_front();
        check("rf_we", {31'h0, rf_we}, {31'h0, e.we});
        check("debug_wen", {28'h0, debug_wb_rf_wen}, {28'h0, {4{e.we}}});
        check("fwd_dest", {27'h0, ws_fwd_dest}, {27'h0, e.we ? e.waddr : 5'd0});
        check("debug_pc", debug_wb_pc, e.pc);
        check("hi_q", hi_q, e.hi);
        check("lo_q", lo_q, e.lo);
        if (e.we) begin
          check("rf_waddr", {27'h0, rf_waddr}, {27'h0, e.waddr});
          check("rf_wdata", rf_wdata, e.wdata);
          check("debug_wdata", debug_wb_rf_wdata, e.wdata);
          check("debug_wnum", {27'h0, debug_wb_rf_wnum}, {27'h0, e.waddr});
        end
      end else begin
        check("idle_rf_we", {31'h0, rf_we}, 32'h0);
        check("idle_fwd", {26'h0, ws_fwd_valid, ws_fwd_dest}, 32'h0);
      end
    end
  end

  initial begin
    ins_t i;
    // Reset held while MEM presents a valid ADDU
    i = blank(); i.pc = 32'hbfc00100; i.dest = 5'd7; i.regwrite = 1'b1; i.result = 32'h77;
    drive_now(i, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_rf_we", {31'h0, rf_we}, 32'h0);
    check("rst_hi", hi_q, 32'h0);
    check("rst_lo", lo_q, 32'h0);
    check("rst_pc", debug_wb_pc, 32'hbfc00000);
    check("rst_wdata", debug_wb_rf_wdata, 32'h0);
    check("rst_wen", {28'h0, debug_wb_rf_wen}, 32'h0);
    check("allowin", {31'h0, ms_if.ws_allowin}, 32'h1);

    @(posedge clk);
    #1;
    reset = 1'b0;
    mon_en = 1'b1;
    // ADDU dest=5, then dest=0
    i = blank(); i.pc = 32'hbfc00000; i.dest = 5'd5; i.regwrite = 1'b1; i.result = 32'h1234;
    drive_now(i, 1'b0, 1'b1);
    i.pc = 32'hbfc00004; i.dest = 5'd0; issue(i, 1'b0);
    // MULT, MFHI, MFLO
    i = blank(); i.pc = 32'hbfc00008; i.hi_write = 1'b1; i.lo_write = 1'b1;
    i.hiw = 32'hdead; i.low = 32'hbeef; issue(i, 1'b0);
    i = blank(); i.pc = 32'hbfc0000c; i.dest = 5'd3; i.regwrite = 1'b1; i.mtr = 2'b01; i.hi_read = 1'b1;
    issue(i, 1'b0);
    i = blank(); i.pc = 32'hbfc00010; i.dest = 5'd4; i.regwrite = 1'b1; i.mtr = 2'b01; i.lo_read = 1'b1;
    issue(i, 1'b0);
    // MTHI then MFHI back to back
    i = blank(); i.pc = 32'hbfc00014; i.hi_write = 1'b1; i.hiw = 32'h7; issue(i, 1'b0);
    i = blank(); i.pc = 32'hbfc00018; i.dest = 5'd9; i.regwrite = 1'b1; i.mtr = 2'b01; i.hi_read = 1'b1;
    issue(i, 1'b0);
    // Illegal hi_read & hi_write: read returns the old HI
    i.pc = 32'hbfc0001c; i.dest = 5'd6; i.hi_write = 1'b1; i.hiw = 32'h5a5a; issue(i, 1'b0);
    i = blank(); i.pc = 32'hbfc00020; i.dest = 5'd10; i.regwrite = 1'b1; i.mtr = 2'b01; i.hi_read = 1'b1;
    issue(i, 1'b0);
    // JAL and MFC0
    i = blank(); i.pc = 32'hbfc00010; i.dest = 5'd31; i.regwrite = 1'b1; i.mtr = 2'b10; i.link = 32'hbfc00018;
    issue(i, 1'b0);
    i = blank(); i.pc = 32'hbfc00024; i.dest = 5'd2; i.regwrite = 1'b1; i.mtr = 2'b11; i.cp0 = 32'h400;
    issue(i, 1'b0);
    // LW in WB while a flushed MTLO arrives; then MFLO shows LO unchanged
    i = blank(); i.pc = 32'hbfc00028; i.dest = 5'd8; i.regwrite = 1'b1; i.result = 32'h55;
    issue(i, 1'b0);
    i = blank(); i.pc = 32'hbfc0002c; i.lo_write = 1'b1; i.low = 32'h9; issue(i, 1'b1);
    idle();
    i = blank(); i.pc = 32'hbfc00030; i.dest = 5'd11; i.regwrite = 1'b1; i.mtr = 2'b01; i.lo_read = 1'b1;
    issue(i, 1'b0);

    // Randomised traffic
    for (int n = 0; n < 400; n++) begin
      i = blank();
      i.valid = ($urandom_range(0, 4) != 0);
      i.pc = $urandom();
      i.dest = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      i.mtr = 2'($urandom_range(0, 3));
      i.regwrite = 1'($urandom_range(0, 1));
      i.hi_read = 1'($urandom_range(0, 1));
      i.lo_read = ~i.hi_read;
      i.hi_write = ($urandom_range(0, 3) == 0);
      i.lo_write = ($urandom_range(0, 3) == 0);
      i.result = $urandom(); i.link = $urandom(); i.cp0 = $urandom();
      i.hiw = $urandom(); i.low = $urandom();
      issue(i, ($urandom_range(0, 7) == 0));
    end
    idle();
    for (int n = 0; n < 50 && sb.size() > 0; n++) @(posedge clk);
    if (sb.size() > 0) begin
      failures++;
      $display("FAIL drain: %0d expected commits never seen", sb.size());
    end

    // Reset pulse while WB holds a MULT
    @(negedge clk);
    mon_en = 1'b0;
    @(posedge clk);
    #1;
    i = blank(); i.pc = 32'hbfc00040; i.hi_write = 1'b1; i.lo_write = 1'b1;
    i.hiw = 32'h1111; i.low = 32'h2222;
    drive_now(i, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    i.valid = 1'b0;
    drive_now(i, 1'b0, 1'b0);
    reset = 1'b1;
    #1;
    check("rst6_rf_we", {31'h0, rf_we}, 32'h0);
    check("rst6_hi", hi_q, 32'h0);
    check("rst6_lo", lo_q, 32'h0);
    check("rst6_pc", debug_wb_pc, 32'hbfc00000);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst6_hi_after", hi_q, 32'h0);
    check("rst6_lo_after", lo_q, 32'h0);
    check("rst6_fwd", {31'h0, ws_fwd_valid}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
